// File: rtl/watch_disp_pkg.sv
// watch_disp_pkg: segment glyphs, display constants and calibration state codes
package watch_disp_pkg;
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] DIG_OFF  = 4'hF;
    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_MIN_L  = 3'd1;
    localparam logic [2:0] ST_MIN_H  = 3'd2;
    localparam logic [2:0] ST_HOUR_L = 3'd3;
    localparam logic [2:0] ST_HOUR_H = 3'd4;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD value plus decimal point to active-low {dp,g,f,e,d,c,b,a}
module seg7_decode
    import watch_disp_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [7:0] glyph;
    always_comb begin
        case (val)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        seg = {~dp, glyph[6:0]};
    end
endmodule

// File: rtl/watch_seg_scan.sv
// watch_seg_scan: multiplexed 4-digit 7-segment scan with colon, calibration blink and dead time
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour tens digit outside hour_h calibration.
module watch_seg_scan
    import watch_disp_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int SCAN_FRE  = 1000,
    parameter int DEAD_CYC  = 16,
    parameter int BLINK_FRE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] minutes_h,
    input  logic [3:0] minutes_l,
    input  logic       second_led,
    input  logic [2:0] state_flag,
    output logic [3:0] dig_sel,
    output logic [7:0] seg_data
);
    localparam int SLOT = CLK_FRE / SCAN_FRE;
    localparam int HALF = CLK_FRE / (2 * BLINK_FRE);
    localparam int CW   = $clog2(SLOT + 1);
    localparam int BW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] DEAD      = CW'(DEAD_CYC);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          blink_phase;
    logic [2:0]    flag_q;
    logic [7:0]    snap;
    logic          flag_chg, blink_on, cal_hit, lz_blank, dp;
    logic [3:0]    digit;
    logic [7:0]    dec, live, cur;

    seg7_decode u_dec (.val(digit), .dp(dp), .seg(dec));

    always_comb begin
        flag_chg = state_flag != flag_q;
        // a freshly selected digit must never start hidden, even on the change cycle
        blink_on = blink_phase && !flag_chg;
        cal_hit  = state_flag >= ST_MIN_L && state_flag <= ST_HOUR_H && state_flag - 3'd1 == {1'b0, idx};
        digit    = idx == 2'd0 ? minutes_l : idx == 2'd1 ? minutes_h : idx == 2'd2 ? hour_l : hour_h;
        dp       = idx == 2'd2 && second_led;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = idx == 2'd3 && hour_h == 4'd0 && state_flag != ST_HOUR_H;
`else
        lz_blank = 1'b0;
`endif
        live     = (cal_hit && blink_on) || lz_blank ? SEG_OFF : dec;
        cur      = cnt == '0 ? live : snap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 2'd0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            flag_q      <= ST_RUN;
            snap        <= SEG_OFF;
            dig_sel     <= DIG_OFF;
            seg_data    <= SEG_OFF;
        end else begin
            cnt         <= cnt == SLOT_LAST ? '0 : cnt + 1'b1;
            idx         <= cnt == SLOT_LAST ? idx + 2'd1 : idx;
            snap        <= cnt == '0 ? live : snap;
            flag_q      <= state_flag;
            bcnt        <= flag_chg || bcnt == HALF_LAST ? '0 : bcnt + 1'b1;
            blink_phase <= flag_chg ? 1'b0 : blink_phase ^ (bcnt == HALF_LAST);
            dig_sel     <= cnt < DEAD ? DIG_OFF : ~(4'b1 << idx);
            seg_data    <= cnt < DEAD ? SEG_OFF : cur;
        end
    end
endmodule

// File: tb/tb_watch_seg_scan.sv
// tb_watch_seg_scan: randomized and directed checks of the display scan against a cycle-count reference model
module tb_watch_seg_scan;
    localparam int SLOT = 10;
    localparam int DEAD = 2;
    localparam int HALF = 250;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] HH_ZERO = 8'hFF;
`else
    localparam logic [7:0] HH_ZERO = 8'hC0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hour_h, hour_l, minutes_h, minutes_l;
    logic       second_led;
    logic [2:0] state_flag;
    logic [3:0] dig_sel;
    logic [7:0] seg_data;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    watch_seg_scan #(.CLK_FRE(1000), .SCAN_FRE(100), .DEAD_CYC(DEAD), .BLINK_FRE(2)) dut (
        .clk(clk), .rst(rst), .hour_h(hour_h), .hour_l(hour_l), .minutes_h(minutes_h),
        .minutes_l(minutes_l), .second_led(second_led), .state_flag(state_flag),
        .dig_sel(dig_sel), .seg_data(seg_data)
    );

    // k = clock edges since reset release, r = edge of the last blink restart
    int         k, r, mc, md;
    bit         mph;
    logic [2:0] prev;
    logic [7:0] msnap, exp_seg;
    logic [3:0] exp_dig;

    function automatic logic [7:0] pattern(int d, bit ph);
        logic [3:0] v;
        bit blank;
        v = d == 0 ? minutes_l : d == 1 ? minutes_h : d == 2 ? hour_l : hour_h;
        blank = ph && state_flag >= 1 && state_flag <= 4 && d == int'(state_flag) - 1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 3 && hour_h == 0 && state_flag != 4) blank = 1;
`endif
        return blank ? 8'hFF : (d == 2 && second_led) ? (GLYPH[v] & 8'h7F) : GLYPH[v];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            k = 0; r = 0; prev = 3'd0; msnap = 8'hFF; exp_dig = 4'hF; exp_seg = 8'hFF;
        end else begin
            k++;
            if (state_flag !== prev) begin r = k; prev = state_flag; end
            mph = (k == r) ? 1'b0 : (((k - 1 - r) / HALF) % 2) == 1;
            mc = (k - 1) % SLOT;
            md = ((k - 1) / SLOT) % 4;
            if (mc == 0) msnap = pattern(md, mph);
            exp_dig = mc < DEAD ? 4'hF : ~(4'b1 << md);
            exp_seg = mc < DEAD ? 8'hFF : msnap;
        end
    end

    task automatic set_time(input logic [3:0] a, b, c, d);
        hour_h = a; hour_l = b; minutes_h = c; minutes_l = d;
    endtask

    task automatic test_reset;
        set_time(4'd1, 4'd2, 4'd3, 4'd4);
        second_led = 1'b1; state_flag = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (17) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1; #1;
        checks++;
        if (dig_sel !== 4'hF || seg_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_async: dig_sel=%h seg_data=%h, expected f ff", dig_sel, seg_data);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel !== (i == 3 ? 4'b1110 : 4'hF) || dig_sel !== exp_dig || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL reset_restart cyc %0d: dig_sel=%h seg_data=%h, expected %h %h", i, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_scan;
        logic [7:0] want;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            want = dig_sel == 4'b1110 ? 8'h99 : dig_sel == 4'b1101 ? 8'hB0 :
                   dig_sel == 4'b1011 ? 8'h24 : dig_sel == 4'b0111 ? 8'hF9 : 8'hFF;
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg || seg_data !== want) begin
                errors++;
                $display("FAIL scan_1234 k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_blink;
        bit seen_on = 0, seen_off = 0;
        state_flag = 3'd3;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dig_sel == 4'b1011) begin
                seen_on  |= seg_data == 8'h24;
                seen_off |= seg_data == 8'hFF;
            end
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL blink_hour_l k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
        checks++;
        if (!(seen_on && seen_off)) begin
            errors++;
            $display("FAIL blink_both_phases: shown=%0d blanked=%0d, expected 1 1", seen_on, seen_off);
        end
        state_flag = 3'd1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg || (dig_sel == 4'b1110 && seg_data !== 8'h99)) begin
                errors++;
                $display("FAIL blink_switch k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_midslot;
        int n = 0;
        state_flag = 3'd0;
        minutes_l = 4'hA;
        repeat (40) @(negedge clk);
        while (dig_sel !== 4'hF && n < 100) begin @(negedge clk); n++; end
        while (dig_sel !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100 || seg_data !== 8'hBF) begin
            errors++;
            $display("FAIL dash_glyph: waited=%0d seg_data=%h, expected bf", n, seg_data);
        end
        repeat (2) @(negedge clk);
        minutes_l = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel !== 4'b1110 || seg_data !== 8'hBF || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL midslot_hold: dig_sel=%h seg_data=%h, expected e bf", dig_sel, seg_data);
            end
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL midslot_next k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_leading_zero;
        bit seen_on = 0, seen_off = 0;
        set_time(4'd0, 4'd7, 4'd0, 4'd5);
        second_led = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg || (i >= 40 && dig_sel == 4'b0111 && seg_data !== HH_ZERO)) begin
                errors++;
                $display("FAIL hour_h_zero k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
        state_flag = 3'd4;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i >= 40 && dig_sel == 4'b0111) begin
                seen_on  |= seg_data == 8'hC0;
                seen_off |= seg_data == 8'hFF;
            end
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL hour_h_cal k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
        checks++;
        if (!(seen_on && seen_off)) begin
            errors++;
            $display("FAIL hour_h_blink: shown=%0d blanked=%0d, expected 1 1", seen_on, seen_off);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) set_time(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(9) == 0) second_led = 1'($urandom);
            if ($urandom_range(299) == 0) state_flag = 3'($urandom);
            @(negedge clk);
            checks++;
            if (dig_sel !== exp_dig || seg_data !== exp_seg) begin
                errors++;
                $display("FAIL random k=%0d: dig_sel=%h seg_data=%h, expected %h %h", k, dig_sel, seg_data, exp_dig, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_blink;
        test_midslot;
        test_leading_zero;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
